// File: rtl/auto_baud_det_if.sv
// Serial-line / result bundle for the auto-baud detector.
// master drives rx and arm; slave (the detector) returns the result.
interface auto_baud_det_if;
  logic       rx;
  logic       arm;
  logic [3:0] baud_mode;
  logic       locked;
  logic       done;
  logic       err;

  modport master (
    output rx, arm,
    input  baud_mode, locked, done, err
  );

  modport slave (
    input  rx, arm,
    output baud_mode, locked, done, err
  );
endinterface

// File: rtl/auto_baud_det.sv
// Auto-baud detector: times the first low pulse after a quiet line and maps it to a rate code.
// Optional AUTOBAUD_CONFIRM_EN: commit only when two consecutive accepted measurements agree.
module auto_baud_det #(
  parameter int TIMEOUT  = 500000,
  parameter int MIN_CNT  = 55,
  parameter int IDLE_CNT = 16
) (
  input  logic           clk,
  input  logic           reset,
  auto_baud_det_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_MEASURE,
    S_CLASSIFY,
    S_LOCK
  } state_t;

  localparam logic [19:0] TIMEOUT_C   = 20'(TIMEOUT);
  localparam logic [19:0] MIN_C       = 20'(MIN_CNT);
  localparam logic [19:0] IDLE_LAST_C = 20'(IDLE_CNT - 1);
  localparam logic [3:0]  MODE_RST    = 4'b0100;

  state_t      r_state;
  state_t      w_next;
  logic        r_rx_p0;
  logic        r_rx_p1;
  logic [19:0] r_cnt;
  logic [19:0] w_cnt_nxt;
  logic [3:0]  r_baud_mode;
  logic        r_locked;
  logic        r_done;
  logic        r_err;
  logic        w_rx_s;
  logic [3:0]  w_mode;
  logic        w_glitch;
  logic        w_accept;
  logic        w_commit;
  logic        w_timeout;
  logic        w_done_set;
  logic        w_err_set;

  // Longest pulse first: the first threshold met selects the slowest matching rate.
  function automatic logic [3:0] classify(input logic [19:0] c);
    logic [3:0] m;
    if      (c >= 20'd208333) m = 4'b0000;
    else if (c >= 20'd62500)  m = 4'b0001;
    else if (c >= 20'd31250)  m = 4'b0010;
    else if (c >= 20'd15625)  m = 4'b0011;
    else if (c >= 20'd7812)   m = 4'b0100;
    else if (c >= 20'd3906)   m = 4'b0101;
    else if (c >= 20'd2170)   m = 4'b0110;
    else if (c >= 20'd1302)   m = 4'b0111;
    else if (c >= 20'd651)    m = 4'b1000;
    else if (c >= 20'd325)    m = 4'b1001;
    else if (c >= 20'd163)    m = 4'b1010;
    else                      m = 4'b1011;
    return m;
  endfunction

  assign w_rx_s    = r_rx_p1;
  assign w_mode    = classify(r_cnt);
  assign w_glitch  = (r_cnt < MIN_C);
  assign w_accept  = (r_state == S_CLASSIFY) && !w_glitch;
  assign w_timeout = (r_cnt >= TIMEOUT_C);

`ifdef AUTOBAUD_CONFIRM_EN
  logic [3:0] r_cand;
  logic       r_cand_vld;

  assign w_commit = w_accept && r_cand_vld && (r_cand == w_mode);

  always_ff @(posedge clk) begin
    if (reset || bus.arm || w_err_set) begin
      r_cand_vld <= 1'b0;
    end else if (r_state == S_CLASSIFY) begin
      if (w_glitch || w_commit) begin
        r_cand_vld <= 1'b0;
      end else begin
        r_cand     <= w_mode;
        r_cand_vld <= 1'b1;
      end
    end
  end
`else
  assign w_commit = w_accept;
`endif

  // Input synchronizer: two flops, idle-high on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_p0 <= 1'b1;
      r_rx_p1 <= 1'b1;
    end else begin
      r_rx_p0 <= bus.rx;
      r_rx_p1 <= r_rx_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.arm) begin
      w_next = S_WAIT_IDLE;
    end else begin
      unique case (r_state)
        S_WAIT_IDLE: if (w_rx_s && (r_cnt == IDLE_LAST_C)) w_next = S_IDLE;
        S_IDLE:      if (!w_rx_s) w_next = S_MEASURE;
        S_MEASURE: begin
          if (w_timeout)   w_next = S_WAIT_IDLE;
          else if (w_rx_s) w_next = S_CLASSIFY;
        end
        S_CLASSIFY:  w_next = w_commit ? S_LOCK : S_IDLE;
        S_LOCK:      w_next = S_LOCK;
        default:     w_next = S_WAIT_IDLE;
      endcase
    end
  end

  // The counter serves both the idle-run length and the low-pulse length.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
    if (bus.arm) begin
      w_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        S_WAIT_IDLE: w_cnt_nxt = (w_rx_s && (r_cnt != IDLE_LAST_C)) ? r_cnt + 20'd1 : '0;
        S_IDLE:      w_cnt_nxt = w_rx_s ? '0 : 20'd1;
        S_MEASURE: begin
          if (w_timeout) begin
            w_err_set = 1'b1;
            w_cnt_nxt = '0;
          end else if (!w_rx_s) begin
            w_cnt_nxt = r_cnt + 20'd1;
          end
        end
        S_CLASSIFY: begin
          w_done_set = w_commit;
          w_cnt_nxt  = '0;
        end
        default:     w_cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_baud_mode <= MODE_RST;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_set;
      r_err  <= w_err_set;
      if (bus.arm) begin
        r_locked <= 1'b0;
      end else if (w_done_set) begin
        r_locked    <= 1'b1;
        r_baud_mode <= w_mode;
      end
    end
  end

  assign bus.baud_mode = r_baud_mode;
  assign bus.locked    = r_locked;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_auto_baud_det.sv
// Scoreboard bench for auto_baud_det: expected done/err events (kind, mode, cycle) are queued
// as pulses are driven and matched by a monitor on the falling edge.
module tb_auto_baud_det;

  localparam int TB_TIMEOUT = 12000;

  typedef struct {
    bit          is_err;
    logic [3:0]  mode;
    int unsigned cyc;
  } ev_t;

  logic        clk;
  logic        reset;
  int unsigned cyc;
  int          n_vec;
  int          n_miss;
  ev_t         sb[$];
  ev_t         mon_e;

  auto_baud_det_if abd ();

  auto_baud_det #(
    .TIMEOUT (TB_TIMEOUT),
    .MIN_CNT (55),
    .IDLE_CNT(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (abd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (abd.done || abd.err)) begin
      chk("done_err_excl", {31'd0, abd.done & abd.err}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_event", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", {31'd0, abd.err}, {31'd0, mon_e.is_err});
        chk("event_cycle", cyc, mon_e.cyc);
        if (!mon_e.is_err) begin
          chk("mode", {28'd0, abd.baud_mode}, {28'd0, mon_e.mode});
          chk("locked_on_done", {31'd0, abd.locked}, 32'd1);
        end
      end
    end
  end

  task automatic idle(input int n);
    abd.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive rx low for exactly low_len cycles; a done, if expected, lands 4 cycles after rx rises.
  task automatic pulse(input int low_len, input bit exp_done, input logic [3:0] mode);
    ev_t e;
    abd.rx = 1'b0;
    repeat (low_len) @(negedge clk);
    abd.rx = 1'b1;
    if (exp_done) begin
      e.is_err = 1'b0;
      e.mode   = mode;
      e.cyc    = cyc + 4;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    repeat (4) @(negedge clk);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic measure(input int gap, input int low_len, input logic [3:0] mode, input string tag);
    idle(gap);
`ifdef AUTOBAUD_CONFIRM_EN
    pulse(low_len, 1'b0, mode);
    idle(20);
`endif
    pulse(low_len, 1'b1, mode);
    drain(tag);
  endtask

  task automatic do_arm();
    abd.arm = 1'b1;
    @(negedge clk);
    abd.arm = 1'b0;
    chk("locked_after_arm", {31'd0, abd.locked}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"},   {28'd0, abd.baud_mode}, 32'h4);
    chk({tag, "_locked"}, {31'd0, abd.locked},    32'd0);
    chk({tag, "_done"},   {31'd0, abd.done},      32'd0);
    chk({tag, "_err"},    {31'd0, abd.err},       32'd0);
  endtask

  initial begin
    automatic ev_t e;
    n_vec   = 0;
    n_miss  = 0;
    reset   = 1'b1;
    abd.rx  = 1'b1;
    abd.arm = 1'b0;
    @(negedge clk);
    do_reset();
    chk_reset_vals("reset");

    // Basic 115200 measurement
    measure(20, 868, 4'b1000, "basic_868");
    chk("locked_basic", {31'd0, abd.locked}, 32'd1);

    // Classification boundaries
    do_arm();
    chk("mode_kept_arm", {28'd0, abd.baud_mode}, 32'h8);
    measure(20, 651, 4'b1000, "b651");
    do_arm();
    measure(20, 650, 4'b1001, "b650");
    do_arm();
    measure(20, 163, 4'b1010, "b163");
    do_arm();
    measure(20, 162, 4'b1011, "b162");

    // Glitch leaves the detector in IDLE: a 2-cycle gap is enough for the next pulse
    do_arm();
    idle(20);
    pulse(54, 1'b0, 4'b0000);
    drain("glitch_54");
    measure(2, 868, 4'b1000, "after_glitch");

    // Locked: rx ignored until arm
    idle(20);
    pulse(434, 1'b0, 4'b0000);
    drain("locked_ignore");
    chk("locked_mode_hold", {28'd0, abd.baud_mode}, 32'h8);
    chk("locked_hold", {31'd0, abd.locked}, 32'd1);
    do_arm();
    measure(20, 434, 4'b1001, "rearm_434");

    // Reset in the middle of a measurement
    do_arm();
    idle(20);
    abd.rx = 1'b0;
    repeat (3000) @(negedge clk);
    do_reset();
    chk_reset_vals("mid_reset");
    repeat (2206) @(negedge clk);
    idle(1);
    drain("mid_reset_quiet");
    measure(20, 5208, 4'b0101, "after_reset_5208");

    // Line break timeout: one err, state retained
    do_reset();
    idle(20);
    e.is_err = 1'b1;
    e.mode   = 4'b0000;
    e.cyc    = cyc + TB_TIMEOUT + 3;
    sb.push_back(e);
    abd.rx = 1'b0;
    repeat (TB_TIMEOUT + 50) @(negedge clk);
    drain("timeout");
    chk("timeout_locked", {31'd0, abd.locked}, 32'd0);
    chk("timeout_mode", {28'd0, abd.baud_mode}, 32'h4);
    measure(16, 10417, 4'b0100, "after_timeout");

`ifdef AUTOBAUD_CONFIRM_EN
    // Disagreeing measurements replace the candidate; only a repeat commits
    do_arm();
    idle(20);
    pulse(868, 1'b0, 4'b0000);
    idle(20);
    pulse(434, 1'b0, 4'b0000);
    idle(20);
    pulse(434, 1'b1, 4'b1001);
    drain("confirm_seq");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/auto_baud_det.md
AUTO_BAUD_DET -- requirements
Module: auto_baud_det

Interface
REQ-001 Parameter TIMEOUT, default 500000, low-pulse count at which a measurement is aborted as a line break.
REQ-002 Parameter MIN_CNT, default 55, shortest low-pulse count accepted as a bit period; shorter pulses are glitches.
REQ-003 Parameter IDLE_CNT, default 16, number of consecutive high synchronized-rx cycles required before arming.
REQ-004 clk  input  1  system clock, 100 MHz; every count is in clk cycles.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 arm  input  1  single-cycle pulse that clears locked and restarts detection.
REQ-008 baud_mode  output  4  detected rate code, same encoding as the baud-rate decoder (0000=300 ... 1011=921600).
REQ-009 locked  output  1  level, high once baud_mode holds a detected value.
REQ-010 done  output  1  single-cycle pulse when baud_mode is updated.
REQ-011 err  output  1  single-cycle pulse on timeout.

Function
REQ-012 rx SHALL pass through a two-flop synchronizer (rx_s); all measurement SHALL use rx_s.
REQ-013 States SHALL be WAIT_IDLE, IDLE, MEASURE, CLASSIFY, LOCK.
REQ-014 WAIT_IDLE: count consecutive rx_s=1 cycles; reaching IDLE_CNT -> IDLE; rx_s=0 clears the count.
REQ-015 IDLE: rx_s=0 -> MEASURE, with the 20-bit counter loaded to 1.
REQ-016 MEASURE: counter increments each rx_s=0 cycle; rx_s=1 -> CLASSIFY.
REQ-017 MEASURE: counter reaching TIMEOUT -> WAIT_IDLE, err pulses for 1 cycle, and baud_mode/locked are unchanged.
REQ-018 CLASSIFY (1 cycle): count < MIN_CNT -> IDLE with no pulse; otherwise mode by first match: >=208333:0000, >=62500:0001, >=31250:0010, >=15625:0011, >=7812:0100, >=3906:0101, >=2170:0110, >=1302:0111, >=651:1000, >=325:1001, >=163:1010, else 1011.
REQ-019 On commit, baud_mode SHALL be registered, locked set to 1, and done pulsed, all visible the cycle after CLASSIFY; state -> LOCK.
REQ-020 Latency: first rx_s=1 cycle in MEASURE = N; done high at N+2.
REQ-021 LOCK: rx ignored; outputs held until arm.
REQ-022 arm in any state SHALL clear locked, keep baud_mode, and go to WAIT_IDLE next cycle; arm has priority over every other transition in the same cycle.
REQ-023 done and err SHALL never be high in the same cycle.

Reset
REQ-024 reset SHALL force state WAIT_IDLE, counters 0, synchronizer flops 1, baud_mode=4'b0100 (9600), locked=0, done=0, err=0.
REQ-025 reset asserted mid-MEASURE SHALL discard the measurement with no done/err pulse; reset has priority over arm.

Configuration
REQ-026 Macro AUTOBAUD_CONFIRM_EN: when defined, a classified mode SHALL commit only if it equals the candidate from the immediately preceding accepted measurement; on mismatch, the new mode SHALL replace the candidate and the block returns to IDLE without pulsing done.
REQ-027 With AUTOBAUD_CONFIRM_EN defined, the candidate SHALL be invalidated by reset, arm, timeout, and glitch rejection.
REQ-028 Without AUTOBAUD_CONFIRM_EN, the first accepted measurement SHALL commit, and no candidate register SHALL exist.

Verification
REQ-029 Reset; rx high 20 cycles; rx low 868 cycles, then high -> done pulse 2 cycles after rx_s rises, baud_mode=1000, locked=1.
REQ-030 Boundaries: low 651 -> 1000; low 650 -> 1001; low 163 -> 1010; low 162 -> 1011; low 54 -> no done, no err, state IDLE.
REQ-031 rx low held 500000 cycles -> err pulse exactly once, locked=0, baud_mode=0100 retained; after rx high 16 cycles, low 10417 -> baud_mode=0100, done.
REQ-032 When locked, rx low 434 -> no change; arm pulse, then rx low 434 -> locked drops the cycle after arm, then baud_mode=1001 with done.
REQ-033 reset raised at count 3000 of a 5208 pulse -> all outputs at reset values, no done; a later low 5208 -> baud_mode=0101.
REQ-034 AUTOBAUD_CONFIRM_EN defined: lows 868, 434, 434 -> done only after the third pulse, baud_mode=1001.
